spad_gate_ctrl: RTL and testbench

SPAD_GATE_CTRL -- requirements
Module: spad_gate_ctrl

---
 rtl/spad_gate_ctrl_if.sv | 21 ++
 rtl/spad_gate_ctrl.sv | 111 +++++++++++
 tb/tb_spad_gate_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/spad_gate_ctrl_if.sv
// Photon/enable inputs and TDC-facing outputs of the SPAD gate controller.
// The master side drives photon and spad_en; the slave side is the controller.
interface spad_gate_ctrl_if;
    logic        photon;
    logic [15:0] spad_en;
    logic        trig;
    logic        time_gate;
    logic [15:0] hit_mask;
    logic [3:0]  pile_cnt;
    logic        armed;

    modport master (
        output photon, spad_en,
        input  trig, time_gate, hit_mask, pile_cnt, armed
    );

    modport slave (
        input  photon, spad_en,
        output trig, time_gate, hit_mask, pile_cnt, armed
    );
endinterface

// File: rtl/spad_gate_ctrl.sv
// SPAD photon gate controller: synchronizes the avalanche, fires the TDC trigger
// and a fixed-width time gate, then holds until tdc_top resets it.
module spad_gate_ctrl #(
    parameter int unsigned GATE_LEN  = 48,
    parameter int unsigned BLANK_LEN = 4
) (
    input  logic           clk_i,
    input  logic           rst_auto,
    spad_gate_ctrl_if.slave bus
);

    localparam logic [7:0] BLANK_LAST = 8'(BLANK_LEN - 1);
    localparam logic [7:0] GATE_LAST  = 8'(GATE_LEN - 1);

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        IDLE  = 2'd1,
        GATE  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  sync_pipe;
    logic        ph_edge, edge_q;
    logic [7:0]  blank_cnt_q, blank_cnt_d;
    logic [7:0]  gate_cnt_q, gate_cnt_d;
    logic [15:0] hit_q, hit_d;
    logic [3:0]  pile_q, pile_d;
    logic        trig_q, tgate_q, armed_q;

    // Two synchronizer flops plus one history flop; the detected edge is
    // registered once more so every output decision comes from flops only.
    assign ph_edge = sync_pipe[1] & ~sync_pipe[2];

    always_ff @(posedge clk_i or negedge rst_auto) begin
        if (!rst_auto) begin
            sync_pipe <= 3'b000;
            edge_q    <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[1:0], bus.photon};
            edge_q    <= ph_edge;
        end
    end

    always_ff @(posedge clk_i or negedge rst_auto) begin
        if (!rst_auto) begin
            state_q     <= BLANK;
            blank_cnt_q <= 8'd0;
            gate_cnt_q  <= 8'd0;
            hit_q       <= 16'd0;
            pile_q      <= 4'd0;
            trig_q      <= 1'b0;
            tgate_q     <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            blank_cnt_q <= blank_cnt_d;
            gate_cnt_q  <= gate_cnt_d;
            hit_q       <= hit_d;
            pile_q      <= pile_d;
            trig_q      <= (state_d == GATE) || (state_d == HOLD);
            tgate_q     <= (state_d == GATE);
            armed_q     <= (state_d == IDLE);
        end
    end

    always_comb begin
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        gate_cnt_d  = gate_cnt_q;
        hit_d       = hit_q;
        pile_d      = pile_q;
        case (state_q)
            BLANK: begin
                if (blank_cnt_q == BLANK_LAST) begin
                    state_d     = IDLE;
                    blank_cnt_d = 8'd0;
                end else begin
                    blank_cnt_d = blank_cnt_q + 8'd1;
                end
            end
            IDLE: begin
                // A hit with no enabled pixel is dropped without leaving IDLE.
                if (edge_q && (bus.spad_en != 16'd0)) begin
                    state_d    = GATE;
                    gate_cnt_d = GATE_LAST;
                    hit_d      = bus.spad_en;
                end
            end
            GATE: begin
                if (edge_q && (pile_q != 4'hF)) pile_d = pile_q + 4'd1;
                if (gate_cnt_q == 8'd0) begin
                    state_d = HOLD;
                end else begin
                    gate_cnt_d = gate_cnt_q - 8'd1;
                end
            end
            HOLD: begin
                if (edge_q && (pile_q != 4'hF)) pile_d = pile_q + 4'd1;
            end
            default: state_d = BLANK;
        endcase
    end

    assign bus.trig      = trig_q;
    assign bus.time_gate = tgate_q;
    assign bus.hit_mask  = hit_q;
    assign bus.pile_cnt  = pile_q;
    assign bus.armed     = armed_q;

endmodule

// File: tb/tb_spad_gate_ctrl.sv
// Directed bench for spad_gate_ctrl: blanking, trigger latency, gate width,
// pile-up saturation, asynchronous reset and pulse-phase sweep.
`timescale 1ns/100ps
module tb_spad_gate_ctrl;

    localparam int unsigned GATE_LEN  = 48;
    localparam int unsigned BLANK_LEN = 4;

    logic clk_i;
    logic rst_auto;
    int   checks = 0;
    int   passes = 0;

    spad_gate_ctrl_if bus ();

    spad_gate_ctrl #(
        .GATE_LEN  (GATE_LEN),
        .BLANK_LEN (BLANK_LEN)
    ) dut (
        .clk_i    (clk_i),
        .rst_auto (rst_auto),
        .bus      (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Asserts reset, checks every output cleared at once, then releases so the
    // next rising edge is the first cycle after release.
    task automatic do_reset(input string tag);
        rst_auto = 1'b0;
        #1;
        chk({tag, "_trig"},  16'(bus.trig), 16'd0);
        chk({tag, "_tgate"}, 16'(bus.time_gate), 16'd0);
        chk({tag, "_hit"},   bus.hit_mask, 16'd0);
        chk({tag, "_pile"},  16'(bus.pile_cnt), 16'd0);
        chk({tag, "_armed"}, 16'(bus.armed), 16'd0);
        tick(2);
        rst_auto = 1'b1;
    endtask

    initial begin
        rst_auto    = 1'b0;
        bus.photon  = 1'b0;
        bus.spad_en = 16'hA5A5;

        // Power-on: outputs cleared, then blanking and a first trigger.
        tick(1);
        do_reset("por");
        tick(BLANK_LEN - 1);
        chk("blank_armed", 16'(bus.armed), 16'd0);
        tick(1);
        chk("armed_after_blank", 16'(bus.armed), 16'd1);
        tick(5);
        bus.photon = 1'b1;
        tick(3);
        chk("lat3_trig", 16'(bus.trig), 16'd0);
        tick(1);
        chk("lat4_trig",  16'(bus.trig), 16'd1);
        chk("lat4_tgate", 16'(bus.time_gate), 16'd1);
        chk("lat4_hit",   bus.hit_mask, 16'hA5A5);
        chk("lat4_armed", 16'(bus.armed), 16'd0);
        chk("lat4_pile",  16'(bus.pile_cnt), 16'd0);
        bus.spad_en = 16'hFFFF;
        tick(2);
        bus.photon = 1'b0;
        tick(45);
        chk("gate_last_hi", 16'(bus.time_gate), 16'd1);
        chk("hit_held",     bus.hit_mask, 16'hA5A5);
        tick(1);
        chk("gate_end_lo",  16'(bus.time_gate), 16'd0);
        chk("hold_trig",    16'(bus.trig), 16'd1);
        chk("hold_pile",    16'(bus.pile_cnt), 16'd0);

        // A hit with no enabled pixel is dropped; an enabled one triggers.
        do_reset("rst2");
        tick(BLANK_LEN);
        bus.spad_en = 16'h0000;
        bus.photon  = 1'b1;
        tick(3);
        bus.photon  = 1'b0;
        tick(5);
        chk("noen_trig",  16'(bus.trig), 16'd0);
        chk("noen_armed", 16'(bus.armed), 16'd1);
        bus.spad_en = 16'h0001;
        bus.photon  = 1'b1;
        tick(3);
        chk("en1_lat3", 16'(bus.trig), 16'd0);
        tick(1);
        chk("en1_trig", 16'(bus.trig), 16'd1);
        chk("en1_hit",  bus.hit_mask, 16'h0001);
        tick(1);
        bus.photon = 1'b0;
        tick(4);

        // Pile-up: 20 pulses, 5 high / 5 low, saturate at 15.
        for (int i = 0; i < 20; i++) begin
            bus.photon = 1'b1;
            tick(5);
            bus.photon = 1'b0;
            tick(5);
            if (i == 2) chk("pile_3", 16'(bus.pile_cnt), 16'd3);
        end
        tick(5);
        chk("pile_sat",   16'(bus.pile_cnt), 16'd15);
        chk("pile_trig",  16'(bus.trig), 16'd1);
        chk("pile_tgate", 16'(bus.time_gate), 16'd0);

        // Reset mid-gate clears everything at once; photon across release is ignored.
        do_reset("rst3");
        tick(BLANK_LEN);
        bus.spad_en = 16'h00F0;
        bus.photon  = 1'b1;
        tick(4);
        chk("mg_trig", 16'(bus.trig), 16'd1);
        chk("mg_hit",  bus.hit_mask, 16'h00F0);
        bus.photon = 1'b0;
        tick(2);
        bus.photon = 1'b1;
        tick(3);
        bus.photon = 1'b0;
        tick(3);
        chk("mg_pile1", 16'(bus.pile_cnt), 16'd1);
        tick(12);
        chk("mg_tgate_hi", 16'(bus.time_gate), 16'd1);
        rst_auto = 1'b0;
        #1;
        chk("async_trig",  16'(bus.trig), 16'd0);
        chk("async_tgate", 16'(bus.time_gate), 16'd0);
        chk("async_pile",  16'(bus.pile_cnt), 16'd0);
        chk("async_hit",   bus.hit_mask, 16'd0);
        bus.photon = 1'b1;
        tick(1);
        rst_auto = 1'b1;
        tick(5);
        bus.photon = 1'b0;
        tick(3);
        chk("blank_ph_trig",  16'(bus.trig), 16'd0);
        chk("blank_ph_armed", 16'(bus.armed), 16'd1);
        bus.photon = 1'b1;
        tick(4);
        chk("rearm_trig", 16'(bus.trig), 16'd1);
        chk("rearm_hit",  bus.hit_mask, 16'h00F0);
        chk("rearm_pile", 16'(bus.pile_cnt), 16'd0);
        bus.photon = 1'b0;

        // Edge seen on the first IDLE cycle triggers with no pile-up.
        do_reset("rst4");
        tick(1);
        bus.photon = 1'b1;
        tick(3);
        chk("first_idle_pre",  16'(bus.trig), 16'd0);
        tick(1);
        chk("first_idle_trig", 16'(bus.trig), 16'd1);
        chk("first_idle_pile", 16'(bus.pile_cnt), 16'd0);
        bus.photon = 1'b0;

        // Phase sweep: 1-cycle pulse never double-counts; 2-cycle always triggers once.
        for (int i = 0; i < 10; i++) begin
            do_reset("sw1");
            tick(BLANK_LEN + 2);
            @(posedge clk_i);
            #(1.0 + 0.8 * i);
            bus.photon = 1'b1;
            #10;
            bus.photon = 1'b0;
            tick(8);
            chk("sweep1_pile", 16'(bus.pile_cnt), 16'd0);
        end
        for (int i = 0; i < 10; i++) begin
            do_reset("sw2");
            tick(BLANK_LEN + 2);
            @(posedge clk_i);
            #(1.0 + 0.8 * i);
            bus.photon = 1'b1;
            #20;
            bus.photon = 1'b0;
            tick(8);
            chk("sweep2_trig", 16'(bus.trig), 16'd1);
            chk("sweep2_pile", 16'(bus.pile_cnt), 16'd0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
